// File: rtl/lane_pipe.sv
// lane_pipe: multi-lane issue pipeline carrying LANES payloads through DEPTH register stages.
// Latency: DEPTH cycles from data_i to data_o with no stalls; each stall_dn cycle adds one.
// Backpressure: stall_dn freezes every stage past S0; stall_up without stall_dn injects a bubble into S0.
//
// Optional feature: define LANE_PIPE_PERF_CNT_EN to add saturating performance counters
// (perf_clr input, stall_cnt / bubble_cnt / kill_cnt outputs). Without it the pipeline is unchanged.
//
// Ports:
//   clk, rst            sole clock (rising edge), asynchronous active-high reset
//   data_i, valid_i     producer payload (lane i at [i*WIDTH +: WIDTH]) and per-lane valid
//   stall_up, stall_dn  producer stalled / consumer (last-stage reader) stalled
//   flush               clear stages S0..S(FLUSH_DEPTH-1)
//   kill_mask           lanes dropped on the S0->S1 transfer (on the S0 load when DEPTH=1)
//   data_o, valid_o     payload and valids of the last stage
//   stage_busy, empty   per-stage OR of lane valids, and "nothing valid anywhere"
module lane_pipe #(
    parameter int LANES       = 2,
    parameter int DEPTH       = 2,
    parameter int WIDTH       = 32,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] data_i,
    input  logic [LANES-1:0]       valid_i,
    input  logic                   stall_up,
    input  logic                   stall_dn,
    input  logic                   flush,
    input  logic [LANES-1:0]       kill_mask,
`ifdef LANE_PIPE_PERF_CNT_EN
    input  logic                   perf_clr,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            bubble_cnt,
    output logic [31:0]            kill_cnt,
`endif
    output logic [LANES*WIDTH-1:0] data_o,
    output logic [LANES-1:0]       valid_o,
    output logic [DEPTH-1:0]       stage_busy,
    output logic                   empty
);

    // ------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------
    logic [LANES-1:0]       vld_q [DEPTH];
    logic [LANES-1:0]       vld_d [DEPTH];
    logic [LANES*WIDTH-1:0] dat_q [DEPTH];
    logic [LANES*WIDTH-1:0] dat_d [DEPTH];

    // Dead lanes always carry an all-zero payload, so every load goes through this.
    function automatic logic [LANES*WIDTH-1:0] zero_dead(
        input logic [LANES*WIDTH-1:0] d,
        input logic [LANES-1:0]       v
    );
        logic [LANES*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            if (v[i]) begin
                r[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage control
    // ------------------------------------------------------------------
    logic             s0_load;    // S0 captures data_i this cycle
    logic             s0_bubble;  // S0 is emptied because the producer stalled
    logic [LANES-1:0] s0_kill;    // kill applied on the S0 load (single-stage build only)
    logic [LANES-1:0] s0_vld_in;
    logic [LANES-1:0] s1_vld_in;

    always_comb begin
        s0_load   = !flush && !stall_up;
        // A stalled producer with a moving consumer must not re-present S0,
        // otherwise the same payload would be delivered twice downstream.
        s0_bubble = !flush && stall_up && !stall_dn;
        // With one stage there is no S0->S1 hop; the kill lands on the input load,
        // and only when the consumer is actually taking the stage this cycle.
        s0_kill   = (DEPTH == 1) ? (kill_mask & {LANES{!stall_dn}}) : '0;
        s0_vld_in = valid_i & ~s0_kill;
        s1_vld_in = vld_q[0] & ~kill_mask;
    end

    // ------------------------------------------------------------------
    // Next-state for every stage
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            vld_d[k] = vld_q[k];
            dat_d[k] = dat_q[k];
        end

        // S0: flush beats bubble beats load; otherwise hold.
        if (flush || s0_bubble) begin
            vld_d[0] = '0;
            dat_d[0] = '0;
        end else if (s0_load) begin
            vld_d[0] = s0_vld_in;
            dat_d[0] = zero_dead(data_i, s0_vld_in);
        end

        // S1 and beyond: flushed stages clear even when the consumer is stalled;
        // stages past the flush window just follow stall_dn.
        for (int k = 1; k < DEPTH; k++) begin
            if (flush && (k < FLUSH_DEPTH)) begin
                vld_d[k] = '0;
                dat_d[k] = '0;
            end else if (!stall_dn) begin
                if (k == 1) begin
                    vld_d[k] = s1_vld_in;
                    dat_d[k] = zero_dead(dat_q[0], s1_vld_in);
                end else begin
                    vld_d[k] = vld_q[k-1];
                    dat_d[k] = dat_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k] <= '0;
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                vld_q[k] <= vld_d[k];
                dat_q[k] <= dat_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken straight from stage flops
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_busy[k] = |vld_q[k];
        end
    end

    assign data_o  = dat_q[DEPTH-1];
    assign valid_o = vld_q[DEPTH-1];
    assign empty   = ~|stage_busy;

`ifdef LANE_PIPE_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    localparam int PCW = $clog2(LANES + 1);

    logic             kill_xfer;    // the hop that honours kill_mask really happens
    logic [LANES-1:0] killed_lanes;
    logic [PCW-1:0]   kill_pop;

    logic [31:0] stall_cnt_q,  stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] kill_cnt_q,   kill_cnt_d;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        if (DEPTH >= 2) begin
            kill_xfer    = !stall_dn && !(flush && (FLUSH_DEPTH >= 2));
            killed_lanes = vld_q[0] & kill_mask;
        end else begin
            kill_xfer    = s0_load && !stall_dn;
            killed_lanes = valid_i & kill_mask;
        end
        kill_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            kill_pop = kill_pop + PCW'(killed_lanes[i]);
        end
    end

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        kill_cnt_d   = kill_cnt_q;
        if (perf_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
            kill_cnt_d   = '0;
        end else begin
            if (stall_dn) begin
                stall_cnt_d = sat_add(stall_cnt_q, 32'd1);
            end
            if (s0_bubble) begin
                bubble_cnt_d = sat_add(bubble_cnt_q, 32'd1);
            end
            if (kill_xfer) begin
                kill_cnt_d = sat_add(kill_cnt_q, 32'(kill_pop));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            kill_cnt_q   <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            kill_cnt_q   <= kill_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign kill_cnt   = kill_cnt_q;
`endif

endmodule

// File: tb/tb_lane_pipe.sv
// tb_lane_pipe: self-checking bench for lane_pipe.
// Instance u_dut2 uses the default shape (2 lanes, 2 stages); u_dut4 has 4 stages, flush window 2.
// Both share one set of inputs; a scoreboard tracks words delivered by u_dut2.
module tb_lane_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] data_i;
    logic [1:0]  valid_i;
    logic        stall_up;
    logic        stall_dn;
    logic        flush;
    logic [1:0]  kill_mask;

    logic [63:0] data_o2, data_o4;
    logic [1:0]  valid_o2, valid_o4;
    logic [1:0]  stage_busy2;
    logic [3:0]  stage_busy4;
    logic        empty2, empty4;
`ifdef LANE_PIPE_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] stall_cnt2, bubble_cnt2, kill_cnt2;
    logic [31:0] stall_cnt4, bubble_cnt4, kill_cnt4;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [63:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    bit   sb_on = 1'b0;

    always #5 clk = ~clk;

    lane_pipe #(.LANES(2), .DEPTH(2), .WIDTH(32), .FLUSH_DEPTH(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .stall_up   (stall_up),
        .stall_dn   (stall_dn),
        .flush      (flush),
        .kill_mask  (kill_mask),
`ifdef LANE_PIPE_PERF_CNT_EN
        .perf_clr   (perf_clr),
        .stall_cnt  (stall_cnt2),
        .bubble_cnt (bubble_cnt2),
        .kill_cnt   (kill_cnt2),
`endif
        .data_o     (data_o2),
        .valid_o    (valid_o2),
        .stage_busy (stage_busy2),
        .empty      (empty2)
    );

    lane_pipe #(.LANES(2), .DEPTH(4), .WIDTH(32), .FLUSH_DEPTH(2)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .stall_up   (stall_up),
        .stall_dn   (stall_dn),
        .flush      (flush),
        .kill_mask  (kill_mask),
`ifdef LANE_PIPE_PERF_CNT_EN
        .perf_clr   (perf_clr),
        .stall_cnt  (stall_cnt4),
        .bubble_cnt (bubble_cnt4),
        .kill_cnt   (kill_cnt4),
`endif
        .data_o     (data_o4),
        .valid_o    (valid_o4),
        .stage_busy (stage_busy4),
        .empty      (empty4)
    );

    // Scoreboard consumer: a word leaves u_dut2 on any edge where the consumer is not stalled.
    always @(negedge clk) begin
        if (sb_on && !rst && !stall_dn && valid_o2 != 2'b00) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got valid_o=%b data_o=%h want no output", valid_o2, data_o2);
            end else begin
                sb_e = sb_q.pop_front();
                if (valid_o2 !== sb_e.v || data_o2 !== sb_e.d) begin
                    failures++;
                    $display("FAIL sb_out got valid_o=%b data_o=%h want valid_o=%b data_o=%h",
                             valid_o2, data_o2, sb_e.v, sb_e.d);
                end
            end
        end
    end

    task automatic idle_inputs;
        data_i    = '0;
        valid_i   = '0;
        kill_mask = '0;
        stall_up  = 1'b0;
        stall_dn  = 1'b0;
        flush     = 1'b0;
`ifdef LANE_PIPE_PERF_CNT_EN
        perf_clr  = 1'b0;
`endif
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic test_reset;
        idle_inputs();
        #1 rst = 1'b1;
        #1;
        checks++; if (valid_o2 !== 2'b00) begin failures++; $display("FAIL rst_valid_o2 got %b want 00", valid_o2); end
        checks++; if (data_o2 !== 64'h0) begin failures++; $display("FAIL rst_data_o2 got %h want 0", data_o2); end
        checks++; if (stage_busy2 !== 2'b00) begin failures++; $display("FAIL rst_busy2 got %b want 00", stage_busy2); end
        checks++; if (empty2 !== 1'b1) begin failures++; $display("FAIL rst_empty2 got %b want 1", empty2); end
        checks++; if (valid_o4 !== 2'b00) begin failures++; $display("FAIL rst_valid_o4 got %b want 00", valid_o4); end
        checks++; if (data_o4 !== 64'h0) begin failures++; $display("FAIL rst_data_o4 got %h want 0", data_o4); end
        checks++; if (stage_busy4 !== 4'b0000) begin failures++; $display("FAIL rst_busy4 got %b want 0000", stage_busy4); end
        checks++; if (empty4 !== 1'b1) begin failures++; $display("FAIL rst_empty4 got %b want 1", empty4); end
`ifdef LANE_PIPE_PERF_CNT_EN
        checks++;
        if (stall_cnt2 !== 32'd0 || bubble_cnt2 !== 32'd0 || kill_cnt2 !== 32'd0) begin
            failures++;
            $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0", stall_cnt2, bubble_cnt2, kill_cnt2);
        end
`endif
        step();
        rst = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e;
        apply_reset();
        sb_on   = 1'b1;
        valid_i = 2'b11;
        data_i  = {32'hB, 32'hA};
        e.v = 2'b11; e.d = {32'hB, 32'hA}; sb_q.push_back(e);
        step();
        valid_i = '0; data_i = '0;
        checks++; if (empty2 !== 1'b0) begin failures++; $display("FAIL basic_empty_c1 got %b want 0", empty2); end
        checks++; if (stage_busy2 !== 2'b01) begin failures++; $display("FAIL basic_busy_c1 got %b want 01", stage_busy2); end
        checks++; if (valid_o2 !== 2'b00) begin failures++; $display("FAIL basic_early_valid got %b want 00", valid_o2); end
        step();
        checks++; if (empty2 !== 1'b0) begin failures++; $display("FAIL basic_empty_c2 got %b want 0", empty2); end
        checks++; if (valid_o2 !== 2'b11) begin failures++; $display("FAIL basic_valid_c2 got %b want 11", valid_o2); end
        checks++; if (data_o2 !== {32'hB, 32'hA}) begin failures++; $display("FAIL basic_data_c2 got %h want %h", data_o2, {32'hB, 32'hA}); end
        step();
        checks++; if (empty2 !== 1'b1) begin failures++; $display("FAIL basic_empty_c3 got %b want 1", empty2); end
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL basic_drain got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_kill;
        exp_t e;
        apply_reset();
        valid_i = 2'b11;
        data_i  = {32'hB, 32'hA};
        e.v = 2'b01; e.d = {32'h0, 32'hA}; sb_q.push_back(e);
        step();
        valid_i = '0; data_i = '0; kill_mask = 2'b10;
        step();
        kill_mask = '0;
        checks++; if (valid_o2 !== 2'b01) begin failures++; $display("FAIL kill_valid got %b want 01", valid_o2); end
        checks++; if (data_o2 !== {32'h0, 32'hA}) begin failures++; $display("FAIL kill_data got %h want %h", data_o2, {32'h0, 32'hA}); end
`ifdef LANE_PIPE_PERF_CNT_EN
        checks++; if (kill_cnt2 !== 32'd1) begin failures++; $display("FAIL kill_cnt got %0d want 1", kill_cnt2); end
`endif
        step();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL kill_drain got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_bubble;
        exp_t e;
        apply_reset();
        valid_i = 2'b11;
        data_i  = {32'h2, 32'h1};
        e.v = 2'b11; e.d = {32'h2, 32'h1}; sb_q.push_back(e);
        step();
        // Producer stalls; the new data_i must never enter S0.
        stall_up = 1'b1;
        data_i   = {32'h4, 32'h3};
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (stage_busy2[0] !== 1'b0) begin failures++; $display("FAIL bubble_s0_%0d got %b want 0", i, stage_busy2[0]); end
            if (i == 0) begin
                checks++;
                if (stage_busy2 !== 2'b10) begin failures++; $display("FAIL bubble_busy got %b want 10", stage_busy2); end
            end
        end
        stall_up = 1'b0; valid_i = '0; data_i = '0;
`ifdef LANE_PIPE_PERF_CNT_EN
        checks++; if (bubble_cnt2 !== 32'd3) begin failures++; $display("FAIL bubble_cnt got %0d want 3", bubble_cnt2); end
`endif
        step();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL bubble_drain got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_stall_dn;
        exp_t e;
        apply_reset();
        valid_i = 2'b01; data_i = {32'h0, 32'h5};
        e.v = 2'b01; e.d = {32'h0, 32'h5}; sb_q.push_back(e);
        step();
        valid_i = 2'b11; data_i = {32'h7, 32'h6};
        // Kill pulses during the stall must not touch this word.
        e.v = 2'b11; e.d = {32'h7, 32'h6}; sb_q.push_back(e);
        step();
        stall_dn = 1'b1; stall_up = 1'b1; valid_i = '0; data_i = '0;
        for (int i = 0; i < 4; i++) begin
            kill_mask = (i % 2 == 0) ? 2'b11 : 2'b00;
            step();
            checks++;
            if (valid_o2 !== 2'b01 || data_o2 !== {32'h0, 32'h5}) begin
                failures++;
                $display("FAIL stall_hold_%0d got valid_o=%b data_o=%h want 01/%h", i, valid_o2, data_o2, {32'h0, 32'h5});
            end
            checks++;
            if (stage_busy2 !== 2'b11) begin failures++; $display("FAIL stall_busy_%0d got %b want 11", i, stage_busy2); end
        end
`ifdef LANE_PIPE_PERF_CNT_EN
        checks++; if (stall_cnt2 !== 32'd4) begin failures++; $display("FAIL stall_cnt got %0d want 4", stall_cnt2); end
        checks++; if (kill_cnt2 !== 32'd0) begin failures++; $display("FAIL stall_kill_cnt got %0d want 0", kill_cnt2); end
`endif
        stall_dn = 1'b0; stall_up = 1'b0; kill_mask = '0;
        step();
        checks++;
        if (valid_o2 !== 2'b11 || data_o2 !== {32'h7, 32'h6}) begin
            failures++;
            $display("FAIL stall_release got valid_o=%b data_o=%h want 11/%h", valid_o2, data_o2, {32'h7, 32'h6});
        end
        step();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL stall_drain got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back;
        localparam int N = 12;
        logic [1:0]  vi [N];
        logic [63:0] dd [N];
        logic [1:0]  km [N+2];
        exp_t        e;
        apply_reset();
        for (int c = 0; c < N + 2; c++) km[c] = 2'($urandom_range(0, 3));
        for (int c = 0; c < N; c++) begin
            vi[c] = 2'($urandom_range(0, 3));
            dd[c] = {$urandom, $urandom};
        end
        for (int c = 0; c < N + 2; c++) begin
            if (c < N) begin
                valid_i = vi[c];
                data_i  = dd[c];
                // Word c sits in S0 during cycle c+1, so that cycle's kill_mask decides its fate.
                e.v = vi[c] & ~km[c+1];
                e.d = '0;
                if (e.v[0]) e.d[31:0]  = dd[c][31:0];
                if (e.v[1]) e.d[63:32] = dd[c][63:32];
                if (e.v != 2'b00) sb_q.push_back(e);
            end else begin
                valid_i = '0;
                data_i  = '0;
            end
            kill_mask = km[c];
            step();
        end
        kill_mask = '0;
        step();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL stream_drain got %0d pending want 0", sb_q.size()); end
        checks++; if (empty2 !== 1'b1) begin failures++; $display("FAIL stream_empty got %b want 1", empty2); end
    endtask

    task automatic test_flush;
        logic [63:0] item [5];
        sb_on = 1'b0;
        for (int k = 0; k < 5; k++) item[k] = {32'h200 + 32'(k), 32'h100 + 32'(k)};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            valid_i = 2'b11; data_i = item[k];
            step();
        end
        checks++; if (stage_busy4 !== 4'b1111) begin failures++; $display("FAIL flush_fill got %b want 1111", stage_busy4); end
        checks++; if (data_o4 !== item[0]) begin failures++; $display("FAIL flush_fill_data got %h want %h", data_o4, item[0]); end
        flush = 1'b1; valid_i = 2'b11; data_i = item[4];
        step();
        flush = 1'b0; valid_i = '0; data_i = '0;
        checks++; if (stage_busy4 !== 4'b1100) begin failures++; $display("FAIL flush_busy got %b want 1100", stage_busy4); end
        checks++; if (data_o4 !== item[1]) begin failures++; $display("FAIL flush_shift_data got %h want %h", data_o4, item[1]); end
        checks++; if (empty2 !== 1'b1) begin failures++; $display("FAIL flush_dut2_empty got %b want 1", empty2); end
        step();
        checks++; if (stage_busy4 !== 4'b1000) begin failures++; $display("FAIL flush_busy2 got %b want 1000", stage_busy4); end
        checks++; if (data_o4 !== item[2]) begin failures++; $display("FAIL flush_shift_data2 got %h want %h", data_o4, item[2]); end
        step();
        checks++;
        if (empty4 !== 1'b1 || valid_o4 !== 2'b00 || data_o4 !== 64'h0) begin
            failures++;
            $display("FAIL flush_empty got empty=%b valid_o=%b data_o=%h want 1/00/0", empty4, valid_o4, data_o4);
        end
        // Flush together with consumer stall: flushed stages clear, later stages hold.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            valid_i = 2'b11; data_i = item[k];
            step();
        end
        flush = 1'b1; stall_dn = 1'b1; valid_i = '0; data_i = '0;
        step();
        flush = 1'b0; stall_dn = 1'b0;
        checks++; if (stage_busy4 !== 4'b1100) begin failures++; $display("FAIL flush_stall_busy got %b want 1100", stage_busy4); end
        checks++; if (data_o4 !== item[0]) begin failures++; $display("FAIL flush_stall_data got %h want %h", data_o4, item[0]); end
    endtask

    task automatic test_reset_mid;
        sb_on = 1'b0;
        apply_reset();
        valid_i = 2'b11; data_i = {32'hC, 32'hD};
        step();
        valid_i = '0; data_i = '0;
        step();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (empty2 !== 1'b1 || valid_o2 !== 2'b00 || data_o2 !== 64'h0) begin
            failures++;
            $display("FAIL midrst_dut2 got empty=%b valid_o=%b data_o=%h want 1/00/0", empty2, valid_o2, data_o2);
        end
        checks++;
        if (empty4 !== 1'b1 || stage_busy4 !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_dut4 got empty=%b busy=%b want 1/0000", empty4, stage_busy4);
        end
        valid_i = 2'b11; data_i = {32'hE, 32'hF};
        #1 rst = 1'b0;
        step();
        checks++; if (stage_busy2 !== 2'b01) begin failures++; $display("FAIL midrst_first_load got %b want 01", stage_busy2); end
        checks++; if (valid_o2 !== 2'b00) begin failures++; $display("FAIL midrst_no_stale got %b want 00", valid_o2); end
        valid_i = '0; data_i = '0;
        step();
        checks++;
        if (valid_o2 !== 2'b11 || data_o2 !== {32'hE, 32'hF}) begin
            failures++;
            $display("FAIL midrst_out got valid_o=%b data_o=%h want 11/%h", valid_o2, data_o2, {32'hE, 32'hF});
        end
    endtask

`ifdef LANE_PIPE_PERF_CNT_EN
    task automatic test_perf_clr;
        sb_on = 1'b0;
        apply_reset();
        stall_dn = 1'b1; stall_up = 1'b1;
        repeat (3) step();
        checks++; if (stall_cnt2 !== 32'd3) begin failures++; $display("FAIL perf_pre got %0d want 3", stall_cnt2); end
        perf_clr = 1'b1;
        step();
        checks++; if (stall_cnt2 !== 32'd0) begin failures++; $display("FAIL perf_clr got %0d want 0", stall_cnt2); end
        perf_clr = 1'b0;
        step();
        checks++; if (stall_cnt2 !== 32'd1) begin failures++; $display("FAIL perf_after got %0d want 1", stall_cnt2); end
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_kill();
        test_bubble();
        test_stall_dn();
        test_back_to_back();
        test_flush();
        test_reset_mid();
`ifdef LANE_PIPE_PERF_CNT_EN
        test_perf_clr();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_pipe.md
LANE_PIPE -- requirements
Module: lane_pipe

Interface
REQ-001 Parameter LANES, default 2: number of issue lanes carried in parallel (1..4).
REQ-002 Parameter DEPTH, default 2: number of register stages, S0..S(DEPTH-1) (1..8).
REQ-003 Parameter WIDTH, default 32: payload bits per lane.
REQ-004 Parameter FLUSH_DEPTH, default 2: number of leading stages cleared by flush (1..DEPTH).
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 data_i  in  LANES*WIDTH  producer payload, lane i in bits [i*WIDTH +: WIDTH].
REQ-008 valid_i  in  LANES  per-lane producer valid.
REQ-009 stall_up  in  1  producer stage stalled.
REQ-010 stall_dn  in  1  consumer (last-stage reader) stalled.
REQ-011 flush  in  1  clear stages S0..S(FLUSH_DEPTH-1).
REQ-012 kill_mask  in  LANES  lanes to invalidate on the S0->S1 transfer (exception not taken by those lanes).
REQ-013 data_o  out  LANES*WIDTH  payload of S(DEPTH-1).
REQ-014 valid_o  out  LANES  per-lane valid of S(DEPTH-1).
REQ-015 stage_busy  out  DEPTH  bit k = OR of lane valids in Sk.
REQ-016 empty  out  1  high when no lane valid in any stage.

Function
REQ-017 Invalid lanes SHALL hold payload all-zero; valid and payload are cleared together.
REQ-018 S0 update priority: flush -> clear; else stall_up && !stall_dn -> clear (bubble); else !stall_up -> load data_i/valid_i masked lane-wise; else hold.
REQ-019 S1 (DEPTH>=2) update priority: flush && FLUSH_DEPTH>=2 -> clear; else !stall_dn -> load S0 with lanes in kill_mask cleared; else hold.
REQ-020 Sk, k>=2: clear if flush && k<FLUSH_DEPTH; else !stall_dn -> load S(k-1); else hold.
REQ-021 With DEPTH=1, kill_mask SHALL apply on the S0 load from data_i instead.
REQ-022 kill_mask SHALL only affect a transfer actually occurring that cycle; ignored while stall_dn=1.
REQ-023 Latency from data_i to data_o: exactly DEPTH cycles with no stalls; each stall cycle adds one.
REQ-024 flush and stall_dn in the same cycle: flush wins for stages < FLUSH_DEPTH; later stages hold.
REQ-025 Outputs data_o, valid_o, stage_busy, empty are registered-state derived, no combinational path from inputs.
REQ-026 empty SHALL equal ~|stage_busy.

Reset
REQ-027 rst asserted SHALL immediately clear all stages: data_o=0, valid_o=0, stage_busy=0, empty=1.
REQ-028 rst mid-transfer SHALL discard all in-flight lanes; first load possible on the first rising edge after rst deasserts.
REQ-029 Performance counters (when present) SHALL reset to 0.

Configuration
REQ-030 Macro LANE_PIPE_PERF_CNT_EN defined: add input perf_clr (1) and outputs stall_cnt (32), bubble_cnt (32), kill_cnt (32).
REQ-031 stall_cnt +1 each cycle stall_dn=1; bubble_cnt +1 each cycle REQ-018 inserts a bubble; kill_cnt +popcount of lanes valid in S0 and killed on an occurring S0->S1 transfer.
REQ-032 Counters saturate at 0xFFFFFFFF; perf_clr zeroes all three next cycle and has priority over increment.
REQ-033 Macro undefined: no counter ports or logic; pipeline behaviour identical.

Verification
REQ-034 LANES=2,DEPTH=2: valid_i=11, data_i={0xB,0xA} at cycle 0, no stalls -> valid_o=11, data_o={0xB,0xA} at cycle 2; empty=0 from cycle 1 through 2.
REQ-035 Same, kill_mask=10 at cycle 1 -> cycle 2 valid_o=01, lane1 payload 0, lane0=0xA; kill_cnt=1.
REQ-036 stall_up=1, stall_dn=0 for 3 cycles -> S0 bubbles, bubble_cnt=3, stage_busy[0]=0.
REQ-037 stall_dn=1 for 4 cycles with S1 holding 0x5 -> data_o=0x5 held 4 cycles, stall_cnt=4, kill_mask pulses ignored.
REQ-038 DEPTH=4,FLUSH_DEPTH=2, all stages valid, flush=1 -> S0,S1 cleared, S2,S3 shift normally; rst pulse mid-run -> empty=1 asynchronously.
